// File: rtl/pe_seq_unit.sv
// Instruction sequencer for a vector PE: walks an async-read instruction ROM, forms
// loop-relative operand addresses, issues PE commands and collects PE results for write-back.
module pe_seq_unit #(
  parameter int PE_ELEMENTS = 4,
  parameter int DATA_LEN    = 32,
  parameter int PC_LEN      = 12,
  parameter int OPCODE_LEN  = 4,
  parameter int DRAM_DEPTH  = 512,
  parameter int INST_LEN    = 16,
  localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH),
  localparam int VEC_W = PE_ELEMENTS * DATA_LEN
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       stall,
  output logic [PC_LEN-1:0]          inst_read_addr,
  input  logic [INST_LEN-1:0]        inst_read_data,
  output logic [DRAM_ADDR_WIDTH-1:0] ram_a_read_addr,
  output logic [DRAM_ADDR_WIDTH-1:0] ram_b_read_addr,
  input  logic [VEC_W-1:0]           ram_a_read_data,
  input  logic [VEC_W-1:0]           ram_b_read_data,
  output logic [VEC_W-1:0]           data_a,
  output logic [VEC_W-1:0]           data_b,
  output logic [3:0]                 pe_opcode,
  input  logic                       pe_stage_1_valid,
  input  logic [VEC_W-1:0]           pe_stage_1_output,
  input  logic                       pe_stage_2_valid,
  input  logic [DATA_LEN-1:0]        pe_stage_2_output,
  input  logic                       store_result,
  output logic                       ram_result_wr_en,
  output logic [DRAM_ADDR_WIDTH-1:0] ram_result_write_addr,
  output logic [VEC_W-1:0]           ram_result_write_data,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [OPCODE_LEN-1:0] OP_ADD          = OPCODE_LEN'(3);
  localparam logic [OPCODE_LEN-1:0] OP_SUB          = OPCODE_LEN'(4);
  localparam logic [OPCODE_LEN-1:0] OP_MUL          = OPCODE_LEN'(5);
  localparam logic [OPCODE_LEN-1:0] OP_DOTP         = OPCODE_LEN'(6);
  localparam logic [OPCODE_LEN-1:0] OP_STORE_S1     = OPCODE_LEN'(7);
  localparam logic [OPCODE_LEN-1:0] OP_STORE_S2     = OPCODE_LEN'(8);
  localparam logic [OPCODE_LEN-1:0] OP_STORE_RESULT = OPCODE_LEN'(9);
  localparam logic [OPCODE_LEN-1:0] OP_STOP         = OPCODE_LEN'(10);
  localparam logic [OPCODE_LEN-1:0] OP_LOOP_BEGIN   = OPCODE_LEN'(11);
  localparam logic [OPCODE_LEN-1:0] OP_LOOP_END     = OPCODE_LEN'(12);

  state_e                     state_q, state_d;
  logic [PC_LEN-1:0]          pc_q, pc_d, loop_start_q, loop_start_d;
  logic [DRAM_ADDR_WIDTH-1:0] offset_q, offset_d, loop_cnt_q, loop_cnt_d;
  logic [DRAM_ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic [VEC_W-1:0]           result_q, result_d;
  logic                       s2v_q;
  logic [OPCODE_LEN-1:0]      opcode;
  logic [DRAM_ADDR_WIDTH-1:0] operand, eff_addr;

  assign opcode   = inst_read_data[OPCODE_LEN-1:0];
  assign operand  = inst_read_data[OPCODE_LEN+DRAM_ADDR_WIDTH-1:OPCODE_LEN];
  // DRAM_DEPTH is a power of two, so the natural adder wrap gives the modulo
  assign eff_addr = operand + offset_q;

  generate
    if (INST_LEN > OPCODE_LEN + DRAM_ADDR_WIDTH) begin : g_spare_bits
      logic unused_inst_bits;
      assign unused_inst_bits = ^inst_read_data[INST_LEN-1:OPCODE_LEN+DRAM_ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    offset_d     = offset_q;
    loop_start_d = loop_start_q;
    loop_cnt_d   = loop_cnt_q;
    res_addr_d   = res_addr_q;
    pe_opcode    = 4'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          pc_d     = '0;
          offset_d = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          pc_d = pc_q + PC_LEN'(1);
          case (opcode)
            OP_ADD:      pe_opcode = 4'd1;
            OP_SUB:      pe_opcode = 4'd2;
            OP_MUL:      pe_opcode = 4'd3;
            OP_DOTP:     pe_opcode = 4'd4;
            OP_STORE_S1: pe_opcode = 4'd5;
            OP_STORE_S2: pe_opcode = 4'd6;
            OP_STORE_RESULT: begin
              pe_opcode  = 4'd7;
              res_addr_d = eff_addr;
            end
            OP_STOP: begin
              pe_opcode = 4'd8;
              pc_d      = pc_q;
              state_d   = DONE;
            end
            OP_LOOP_BEGIN: begin
              loop_start_d = pc_q + PC_LEN'(1);
              loop_cnt_d   = (operand == '0) ? DRAM_ADDR_WIDTH'(1) : operand;
            end
            OP_LOOP_END: begin
              // Each taken iteration bumps the offset so the body walks consecutive addresses
              if (loop_cnt_q > DRAM_ADDR_WIDTH'(1)) begin
                loop_cnt_d = loop_cnt_q - DRAM_ADDR_WIDTH'(1);
                offset_d   = offset_q + DRAM_ADDR_WIDTH'(1);
                pc_d       = loop_start_q;
              end else begin
                offset_d = '0;
              end
            end
            default: ;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage-1 loads all lanes; a delayed stage-2 valid shifts a scalar into lane 0
  always_comb begin
    result_d = result_q;
    if (!store_result) begin
      if (pe_stage_1_valid) begin
        result_d = pe_stage_1_output;
      end else if (s2v_q) begin
        result_d = {result_q[VEC_W-DATA_LEN-1:0], pe_stage_2_output};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      offset_q     <= '0;
      loop_start_q <= '0;
      loop_cnt_q   <= '0;
      res_addr_q   <= '0;
      result_q     <= '0;
      s2v_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      offset_q     <= offset_d;
      loop_start_q <= loop_start_d;
      loop_cnt_q   <= loop_cnt_d;
      res_addr_q   <= res_addr_d;
      result_q     <= result_d;
      s2v_q        <= pe_stage_2_valid;
    end
  end

  assign inst_read_addr        = pc_q;
  assign ram_a_read_addr       = eff_addr;
  assign ram_b_read_addr       = eff_addr;
  assign data_a                = ram_a_read_data;
  assign data_b                = ram_b_read_data;
  assign ram_result_wr_en      = store_result;
  assign ram_result_write_addr = res_addr_q;
  assign ram_result_write_data = result_q;
  assign busy                  = (state_q == RUN);
  assign done                  = (state_q == DONE);

endmodule

// File: doc/pe_seq_unit.md
PE_SEQ_UNIT -- requirements
Module: pe_seq_unit

Interface
REQ-001 SHALL have parameter PE_ELEMENTS, default 4, lanes per vector.
REQ-002 SHALL have parameter DATA_LEN, default 32, bits per lane.
REQ-003 SHALL have parameter PC_LEN, default 12, program counter width.
REQ-004 SHALL have parameter OPCODE_LEN, default 4, opcode field width.
REQ-005 SHALL have parameter DRAM_DEPTH, default 512, data RAM depth (power of two); DRAM_ADDR_WIDTH = clog2(DRAM_DEPTH).
REQ-006 SHALL have parameter INST_LEN, default 16, instruction width; INST_LEN >= OPCODE_LEN + DRAM_ADDR_WIDTH.
REQ-007 Ports SHALL be:
  clk  in  1  clock, rising edge.
  rstn  in  1  reset, asynchronous, active-low.
  start  in  1  single-cycle program launch request.
  stall  in  1  freeze sequencing this cycle.
  inst_read_addr  out  PC_LEN  instruction ROM address (= pc).
  inst_read_data  in  INST_LEN  ROM data, valid same cycle (async-read ROM).
  ram_a_read_addr, ram_b_read_addr  out  DRAM_ADDR_WIDTH  operand addresses.
  ram_a_read_data, ram_b_read_data  in  PE_ELEMENTS*DATA_LEN  operand vectors.
  data_a, data_b  out  PE_ELEMENTS*DATA_LEN  combinational pass-through of RAM read data.
  pe_opcode  out  4  PE command.
  pe_stage_1_valid  in  1;  pe_stage_1_output  in  PE_ELEMENTS*DATA_LEN.
  pe_stage_2_valid  in  1;  pe_stage_2_output  in  DATA_LEN.
  store_result  in  1  PE commit strobe.
  ram_result_wr_en  out  1;  ram_result_write_addr  out  DRAM_ADDR_WIDTH;  ram_result_write_data  out  PE_ELEMENTS*DATA_LEN.
  busy  out  1  high in RUN.
  done  out  1  one-cycle completion pulse.

Function
REQ-008 Instruction fields SHALL be opcode = inst[OPCODE_LEN-1:0], operand = inst[OPCODE_LEN+DRAM_ADDR_WIDTH-1:OPCODE_LEN].
REQ-009 Opcode encoding SHALL be: NOOP 0, FETCH_A 1, FETCH_B 2, ADD 3, SUB 4, MUL 5, DOTP 6, STORE_TEMP_S1 7, STORE_TEMP_S2 8, STORE_RESULT 9, STOP 10, LOOP_BEGIN 11, LOOP_END 12, others treated as NOOP.
REQ-010 FSM SHALL have states IDLE, RUN, DONE: IDLE->RUN on start (pc<=0, offset<=0); RUN->DONE when STOP decoded and stall=0; DONE->IDLE unconditionally after one cycle with done=1.
REQ-011 start SHALL be ignored outside IDLE.
REQ-012 In RUN with stall=0, pc SHALL advance by 1 per cycle except on STOP (hold) and taken LOOP_END (pc<=loop_start).
REQ-013 pc SHALL wrap modulo 2^PC_LEN.
REQ-014 pe_opcode SHALL be: FETCH_A/FETCH_B/NOOP 0, ADD 1, SUB 2, MUL 3, DOTP 4, STORE_TEMP_S1 5, STORE_TEMP_S2 6, STORE_RESULT 7, STOP 8, LOOP_* 0; forced 0 when not in RUN or when stall=1.
REQ-015 Effective address SHALL be (operand + offset) mod DRAM_DEPTH; ram_a/b_read_addr SHALL carry it combinationally every cycle.
REQ-016 LOOP_BEGIN (stall=0) SHALL set loop_start<=pc+1 and loop_cnt<=operand, where operand 0 is treated as 1; nesting is unsupported, a second LOOP_BEGIN overwrites.
REQ-017 LOOP_END (stall=0) SHALL, if loop_cnt>1, decrement loop_cnt, increment offset by 1, and jump pc to loop_start; otherwise fall through (pc+1) and clear offset to 0.
REQ-018 STORE_RESULT (stall=0) SHALL latch the effective address into res_addr.
REQ-019 pe_stage_2_valid SHALL be registered one cycle (s2v_d).
REQ-020 Result register SHALL update only when store_result=0: pe_stage_1_valid loads all lanes from pe_stage_1_output; else s2v_d shifts lanes up by one with pe_stage_2_output entering lane 0; stage-1 wins when both are active.
REQ-021 ram_result_wr_en SHALL equal store_result; write_addr = res_addr; write_data = result register.
REQ-022 stall SHALL freeze pc, loop_start, loop_cnt, offset, res_addr and FSM state; result capture SHALL continue during stall.

Reset
REQ-023 rstn=0 SHALL asynchronously force IDLE with pc, offset, loop_start, loop_cnt, res_addr, result and s2v_d all zero; busy=0, done=0, pe_opcode=0.
REQ-024 Reset asserted mid-RUN SHALL abort the program; no done pulse is generated.

Verification
REQ-025 Program {FETCH_A 5, FETCH_B 9, ADD, STOP}, start pulse -> pe_opcode 0,0,1,8; ram_a_read_addr=5 in cycle 1; done high exactly 1 cycle after STOP.
REQ-026 {LOOP_BEGIN 3, FETCH_A 10, LOOP_END, STOP} -> FETCH_A addresses 10,11,12; offset=0 afterwards; STOP reached.
REQ-027 stall held 3 cycles mid-program -> pc constant, pe_opcode=0 during stall, sequence otherwise unchanged.
REQ-028 stage1 output {4,3,2,1}, then two stage-2 outputs 7, 8 -> result {2,1,7,8} (lane3..0); store_result=1 with STORE_RESULT 20 -> wr_en=1, addr=20.
REQ-029 rstn low during loop iteration 2 -> immediate IDLE, all outputs 0, next start executes from pc 0.
REQ-030 DRAM_DEPTH=512, FETCH_A 511 inside a 2-iteration loop -> addresses 511, 0 (wrap).
